// File: rtl/ps2_defs.sv
// ps2_defs: shared state encoding, timing defaults and command bytes for the PS/2 host transmitter.
package ps2_defs;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ_START, SEND, WAIT_ACK, DONE} state_e;
  localparam int CLK_INHIBIT_DEFAULT = 5000;
  localparam int START_TIMEOUT_DEFAULT = 750000;
  localparam int XFER_TIMEOUT_DEFAULT = 100000;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizer for one PS/2 line plus falling-edge detect on the synced value.
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic sync_o,
  output logic fall_o
);
  // [0] metastable stage, [1] synced value, [2] synced value one cycle earlier
  logic [2:0] sh_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sh_q <= 3'b111;
    else sh_q <= {sh_q[1:0], line_i};
  end
  assign sync_o = sh_q[1];
  assign fall_o = sh_q[2] & ~sh_q[1];
endmodule

// File: rtl/ps2_command_tx.sv
// ps2_command_tx: host-to-device PS/2 command transmitter with inhibit, start request,
// bit shifting on device clock edges, ack check and start/transfer timeouts.
module ps2_command_tx
  import ps2_defs::*;
#(
  parameter int CLK_INHIBIT_CYCLES   = CLK_INHIBIT_DEFAULT,
  parameter int START_TIMEOUT_CYCLES = START_TIMEOUT_DEFAULT,
  parameter int XFER_TIMEOUT_CYCLES  = XFER_TIMEOUT_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [7:0] command_data,
  input  logic       send_command,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_timed_out,
  output logic       error_no_ack
);
  localparam int IW = $clog2(CLK_INHIBIT_CYCLES) + 1;
  localparam int SW = $clog2(START_TIMEOUT_CYCLES) + 1;
  localparam int XW = $clog2(XFER_TIMEOUT_CYCLES) + 1;

  state_e        state_q;
  logic          clk_oe_q, dat_oe_q;
  logic [8:0]    sh_q;
  logic [3:0]    bit_q;
  logic [IW-1:0] inh_q;
  logic [SW-1:0] st_q;
  logic [XW-1:0] xf_q;
  logic          sent_q, to_q, nack_q;
  logic          clk_sync, clk_fall, dat_sync, dat_fall_unused;

  ps2_line_sync u_clk_sync (.clk_i(CLOCK_50), .rst_ni(reset_n), .line_i(PS2_CLK),
                            .sync_o(clk_sync), .fall_o(clk_fall));
  ps2_line_sync u_dat_sync (.clk_i(CLOCK_50), .rst_ni(reset_n), .line_i(PS2_DAT),
                            .sync_o(dat_sync), .fall_o(dat_fall_unused));

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      sh_q     <= '0;
      bit_q    <= '0;
      inh_q    <= '0;
      st_q     <= '0;
      xf_q     <= '0;
      sent_q   <= 1'b0;
      to_q     <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      sent_q <= 1'b0;
      to_q   <= 1'b0;
      nack_q <= 1'b0;
      case (state_q)
        IDLE: if (send_command) begin
          sh_q     <= {odd_parity(command_data), command_data};
          inh_q    <= '0;
          st_q     <= '0;
          xf_q     <= '0;
          bit_q    <= '0;
          clk_oe_q <= 1'b1;
          dat_oe_q <= CLK_INHIBIT_CYCLES == 1;
          state_q  <= INHIBIT;
        end
        INHIBIT: begin
          if (inh_q == IW'(CLK_INHIBIT_CYCLES - 1)) begin
            clk_oe_q <= 1'b0;
            state_q  <= REQ_START;
          end else inh_q <= inh_q + 1'b1;
          if (inh_q == IW'(CLK_INHIBIT_CYCLES - 2)) dat_oe_q <= 1'b1;
        end
        REQ_START: begin
          if (clk_fall) begin
            dat_oe_q <= ~sh_q[0];
            sh_q     <= {1'b1, sh_q[8:1]};
            bit_q    <= 4'd1;
            xf_q     <= XW'(1);
            state_q  <= SEND;
          end else if (st_q == SW'(START_TIMEOUT_CYCLES - 1)) begin
            to_q     <= 1'b1;
            dat_oe_q <= 1'b0;
            state_q  <= IDLE;
          end else if (~&st_q) st_q <= st_q + 1'b1;
        end
        SEND, WAIT_ACK: begin
          if (~&xf_q) xf_q <= xf_q + 1'b1;
          // an edge in the same cycle as expiry wins over the timeout
          if (clk_fall) begin
            if (state_q == WAIT_ACK) begin
              sent_q  <= ~dat_sync;
              nack_q  <= dat_sync;
              state_q <= DONE;
            end else begin
              dat_oe_q <= ~sh_q[0];
              sh_q     <= {1'b1, sh_q[8:1]};
              bit_q    <= bit_q + 1'b1;
              if (bit_q == 4'd9) state_q <= WAIT_ACK;
            end
          end else if (xf_q == XW'(XFER_TIMEOUT_CYCLES - 1)) begin
            to_q     <= 1'b1;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        DONE: if (clk_sync && dat_sync) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PS2_CLK          = clk_oe_q ? 1'b0 : 1'bz;
  assign PS2_DAT          = dat_oe_q ? 1'b0 : 1'bz;
  assign busy             = state_q != IDLE;
  assign command_was_sent = sent_q;
  assign error_timed_out  = to_q;
  assign error_no_ack     = nack_q;
endmodule

// File: tb/tb_ps2_command_tx.sv
// tb_ps2_command_tx: directed bench with an open-drain PS/2 device model clocking at a 40-cycle period.
module tb_ps2_command_tx;
  import ps2_defs::*;
  localparam int HALF = 20;
  localparam int SYNC_LAT = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n;
  logic [7:0] command_data;
  logic       send_command;
  logic       busy, command_was_sent, error_timed_out, error_no_ack;
  logic       dev_clk_low, dev_dat_low;
  wire        ps2_clk, ps2_dat;

  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  int n_sent = 0, n_nack = 0, n_to = 0, n_multi = 0;
  int t_req, t_edge1, at, s_sent, s_nack, s_to;
  logic [9:0] bits;
  logic busy_at11;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

  ps2_command_tx #(
    .CLK_INHIBIT_CYCLES(50), .START_TIMEOUT_CYCLES(2000), .XFER_TIMEOUT_CYCLES(1500)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .command_data(command_data),
    .send_command(send_command), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat), .busy(busy),
    .command_was_sent(command_was_sent), .error_timed_out(error_timed_out),
    .error_no_ack(error_no_ack)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    if (command_was_sent) n_sent <= n_sent + 1;
    if (error_no_ack) n_nack <= n_nack + 1;
    if (error_timed_out) n_to <= n_to + 1;
    if ($countones({command_was_sent, error_no_ack, error_timed_out}) > 1) n_multi <= n_multi + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_sent = n_sent; s_nack = n_nack; s_to = n_to;
  endtask

  // request a command and measure the inhibit pulse; returns on the first REQ_START cycle
  task automatic start_cmd(input logic [7:0] cmd);
    int n_low = 0, n_dlow = 0;
    snap();
    command_data = cmd;
    send_command = 1'b1;
    @(negedge CLOCK_50);
    send_command = 1'b0;
    while (ps2_clk === 1'b0 && n_low < 1000) begin
      n_low++;
      if (ps2_dat === 1'b0) n_dlow++;
      @(negedge CLOCK_50);
    end
    t_req = cyc;
    check("inhibit_len", n_low, 50);
    check("inhibit_dat_low", n_dlow, 1);
    check("start_bit", {31'd0, ps2_dat}, 0);
    check("busy_req", {31'd0, busy}, 1);
  endtask

  task automatic device(input int n_edges, input bit ack, input bit poke, output logic [9:0] b);
    b = '0;
    for (int e = 1; e <= n_edges; e++) begin
      if (e == 11 && ack) dev_dat_low = 1'b1;
      repeat (HALF) @(negedge CLOCK_50);
      dev_clk_low = 1'b1;
      if (e == 1) t_edge1 = cyc;
      if (poke && e == 3) begin
        command_data = 8'h00;
        send_command = 1'b1;
      end
      repeat (HALF) @(negedge CLOCK_50);
      send_command = 1'b0;
      if (e <= 10) b[e-1] = ps2_dat;
      if (e == 11) busy_at11 = busy;
      dev_clk_low = 1'b0;
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_timeout(output int t);
    int k = 0;
    while (error_timed_out !== 1'b1 && k < 4000) begin
      @(negedge CLOCK_50);
      k++;
    end
    t = cyc;
  endtask

  initial begin
    reset_n = 1'b0; send_command = 1'b0; command_data = '0;
    dev_clk_low = 1'b0; dev_dat_low = 1'b0; busy_at11 = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_pulses", {29'd0, command_was_sent, error_timed_out, error_no_ack}, 0);
    check("rst_lines", {30'd0, ps2_clk, ps2_dat}, 3);
    reset_n = 1'b1;
    repeat (5) @(negedge CLOCK_50);

    // SET_LEDS with ack
    start_cmd(CMD_SET_LEDS);
    device(11, 1'b1, 1'b0, bits);
    repeat (5) @(negedge CLOCK_50);
    check("ed_bits", {22'd0, bits}, 32'h3ED);
    check("ed_parity", {31'd0, bits[8]}, 1);
    check("ed_stop", {31'd0, bits[9]}, 1);
    check("ed_sent", n_sent - s_sent, 1);
    check("ed_nack", n_nack - s_nack, 0);
    check("ed_busy_end", {31'd0, busy}, 0);

    // ENABLE, device holds data high at edge 11
    start_cmd(CMD_ENABLE);
    device(11, 1'b0, 1'b0, bits);
    repeat (5) @(negedge CLOCK_50);
    check("f4_bits", {22'd0, bits}, 32'h2F4);
    check("f4_parity", {31'd0, bits[8]}, 0);
    check("f4_nack", n_nack - s_nack, 1);
    check("f4_sent", n_sent - s_sent, 0);
    check("f4_busy_at11", {31'd0, busy_at11}, 1);
    check("f4_busy_end", {31'd0, busy}, 0);

    // RESET command to a silent device
    start_cmd(CMD_RESET);
    wait_timeout(at);
    check("start_to_delay", at - t_req, 2000);
    check("start_to_lines", {30'd0, ps2_clk, ps2_dat}, 3);
    check("start_to_idle", {31'd0, busy}, 0);
    repeat (3) @(negedge CLOCK_50);
    check("start_to_count", n_to - s_to, 1);

    // device stops clocking after edge 4
    start_cmd(CMD_SET_LEDS);
    device(4, 1'b0, 1'b0, bits);
    wait_timeout(at);
    check("xfer_to_delay", at - t_edge1, 1500 + SYNC_LAT);
    check("xfer_to_lines", {30'd0, ps2_clk, ps2_dat}, 3);
    check("xfer_to_idle", {31'd0, busy}, 0);
    repeat (3) @(negedge CLOCK_50);
    check("xfer_to_count", n_to - s_to, 1);
    check("xfer_to_sent", n_sent - s_sent, 0);

    // new request with 8'h00 during SEND must not disturb the byte in flight
    start_cmd(CMD_SET_LEDS);
    device(11, 1'b1, 1'b1, bits);
    repeat (5) @(negedge CLOCK_50);
    check("poke_bits", {22'd0, bits}, 32'h3ED);
    check("poke_sent", n_sent - s_sent, 1);
    check("poke_busy_end", {31'd0, busy}, 0);

    // reset while bit 5 (D4 = 0) is on the line
    start_cmd(CMD_SET_LEDS);
    device(5, 1'b0, 1'b0, bits);
    check("mid_bits", {27'd0, bits[4:0]}, 32'h0D);
    check("mid_dat_driven", {31'd0, ps2_dat}, 0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_lines", {30'd0, ps2_clk, ps2_dat}, 3);
    check("mid_rst_busy", {31'd0, busy}, 0);
    repeat (10) @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    check("mid_rst_pulses", (n_sent - s_sent) + (n_nack - s_nack) + (n_to - s_to), 0);
    start_cmd(CMD_SET_LEDS);
    device(11, 1'b1, 1'b0, bits);
    repeat (5) @(negedge CLOCK_50);
    check("after_rst_bits", {22'd0, bits}, 32'h3ED);
    check("after_rst_sent", n_sent - s_sent, 1);
    check("one_hot_pulses", n_multi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
